// File: rtl/io_uart_tx_if.sv
// CPU-facing bus of the UART transmitter: the CPU io_out word in, the status word
// back to the CPU io_in port, and the serial line.
interface io_uart_tx_if;
  logic [31:0] io_out;
  logic [31:0] status;
  logic        tx;

  modport master (output io_out, input status, input tx);
  modport slave  (input io_out, output status, output tx);
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: toggle-strobed byte writes are queued in a small
// circular FIFO and serialized LSB first on tx.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input logic         clk,
  input logic         rst,
  io_uart_tx_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          prev_toggle, ack_toggle, overflow;

  logic write_req, bit_end, full, pop, push, drop, tx_busy;
  logic unused_bits;

  assign unused_bits = ^bus.io_out[31:10];

  assign write_req = bus.io_out[8] != prev_toggle;
  assign bit_end   = bit_cnt == CW'(CLKS_PER_BIT - 1);
  assign full      = count == 3'(FIFO_DEPTH);
  assign pop       = (count != 3'd0) && ((state == IDLE) || (state == STOP && bit_end));
  // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
  assign push      = write_req && (!full || pop);
  assign drop      = write_req && full && !pop;
  assign tx_busy   = (state != IDLE) || (count != 3'd0);

  assign bus.status = {26'd0, count, overflow, tx_busy, ack_toggle};
  assign bus.tx     = tx_q;

  // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.io_out[7:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= 3'd0;
      prev_toggle <= 1'b0;
      ack_toggle  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (write_req) begin
        prev_toggle <= bus.io_out[8];
        ack_toggle  <= bus.io_out[8];
      end
      if (drop)               overflow <= 1'b1;
      else if (bus.io_out[9]) overflow <= 1'b0;

      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            tx_q    <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift[0];
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx_q    <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            // Chain straight into the next start bit when more data is waiting.
            if (pop) begin
              shift <= mem[rd_ptr];
              tx_q  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: a frame-timing reference model predicts status
// and the tx waveform each cycle.
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_uart_tx_if bus ();

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of waiting bytes plus the edge at which the current frame began.
  logic [7:0]  m_q [$];
  logic        m_prev = 1'b0, m_ack = 1'b0, m_ovf = 1'b0;
  longint      m_edge = 0, m_pop_edge = 0, m_busy_until = 0;
  logic [7:0]  m_frame = 8'd0;
  logic [31:0] exp_status;
  logic        exp_tx;
  logic        tog = 1'b0;

  task automatic tick(input logic r, input logic [31:0] v);
    logic   do_pop, wr, take, lost, active;
    longint k;
    int     slot;
    bus.io_out = v;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_prev = 1'b0;
      m_ack = 1'b0;
      m_ovf = 1'b0;
      m_busy_until = 0;
    end else begin
      do_pop = (m_q.size() > 0) && (m_edge >= m_busy_until);
      wr = v[8] != m_prev;
      take = 1'b0;
      lost = 1'b0;
      if (wr) begin
        m_prev = v[8];
        m_ack = v[8];
        if (m_q.size() < DEPTH || do_pop) take = 1'b1;
        else lost = 1'b1;
      end
      if (lost) m_ovf = 1'b1;
      else if (v[9]) m_ovf = 1'b0;
      if (do_pop) begin
        m_frame = m_q.pop_front();
        m_pop_edge = m_edge;
        m_busy_until = m_edge + 10 * CPB;
      end
      if (take) m_q.push_back(v[7:0]);
    end
    active = m_edge < m_busy_until;
    exp_tx = 1'b1;
    if (active) begin
      k = m_edge - m_pop_edge;
      slot = int'(k) / CPB;
      if (slot == 0) exp_tx = 1'b0;
      else if (slot <= 8) exp_tx = m_frame[slot-1];
    end
    exp_status = {26'd0, 3'(m_q.size()), m_ovf, active || (m_q.size() != 0), m_ack};
    m_edge++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 32'h1FF);
      checks++;
      if (bus.status !== 32'h0 || bus.tx !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold status=%h tx=%b expected status=0 tx=1", bus.status, bus.tx);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0);
      checks++;
      if (bus.status !== exp_status || bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL reset_release status=%h/%h tx=%b/%b", bus.status, exp_status, bus.tx, exp_tx);
      end
    end
  endtask

  task automatic test_single();
    tick(1'b0, 32'h000);
    tick(1'b0, 32'h155);
    tog = 1'b1;
    checks++;
    if (bus.status !== 32'hB) begin
      failures++;
      $display("FAIL single_accept status=%h expected=0000000b", bus.status);
    end
    tick(1'b0, 32'h155);
    checks++;
    if (bus.status !== 32'h3 || bus.tx !== 1'b0) begin
      failures++;
      $display("FAIL single_pop status=%h tx=%b expected status=00000003 tx=0", bus.status, bus.tx);
    end
    for (int i = 0; i < 45; i++) begin
      tick(1'b0, 32'h155);
      checks++;
      if (bus.status !== exp_status || bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL single_frame cyc=%0d status=%h/%h tx=%b/%b", i, bus.status, exp_status, bus.tx, exp_tx);
      end
    end
    checks++;
    if (bus.status !== 32'h1 || bus.tx !== 1'b1) begin
      failures++;
      $display("FAIL single_done status=%h tx=%b expected status=00000001 tx=1", bus.status, bus.tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic        started = 1'b0, finished = 1'b0;
    int          act = 0;
    for (int i = 0; i < 200 && !finished; i++) begin
      v = (i == 0) ? 32'h0A1 : 32'h13C;
      tick(1'b0, v);
      checks++;
      if (bus.status !== exp_status || bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL b2b_frame cyc=%0d status=%h/%h tx=%b/%b", i, bus.status, exp_status, bus.tx, exp_tx);
      end
      if (!started && bus.tx === 1'b0) started = 1'b1;
      if (started) begin
        if (bus.status[1] === 1'b0) finished = 1'b1;
        else act++;
      end
    end
    tog = 1'b1;
    checks++;
    if (!finished || act != 80) begin
      failures++;
      $display("FAIL b2b_duration active_cycles=%0d finished=%b expected=80", act, finished);
    end
  endtask

  task automatic drain(input string name);
    logic idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      tick(1'b0, {22'd0, 1'b0, tog, 8'h00});
      checks++;
      if (bus.status !== exp_status || bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL %s_drain cyc=%0d status=%h/%h tx=%b/%b", name, i, bus.status, exp_status, bus.tx, exp_tx);
      end
      idle = !exp_status[1];
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL %s_timeout transmitter still busy status=%h", name, bus.status);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      tog = ~tog;
      tick(1'b0, {22'd0, 1'b0, tog, 8'($urandom)});
      checks++;
      if (bus.status !== exp_status || bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL ovf_write cyc=%0d status=%h/%h tx=%b/%b", i, bus.status, exp_status, bus.tx, exp_tx);
      end
    end
    checks++;
    if (bus.status[2] !== 1'b1 || bus.status[5:3] !== 3'd4 || bus.status[0] !== tog) begin
      failures++;
      $display("FAIL ovf_flag status=%h expected ovf=1 count=4 ack=%b", bus.status, tog);
    end
    tick(1'b0, {22'd0, 1'b1, tog, 8'h00});
    checks++;
    if (bus.status[2] !== 1'b0 || bus.status !== exp_status) begin
      failures++;
      $display("FAIL ovf_clear status=%h/%h", bus.status, exp_status);
    end
    drain("ovf");
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 5; i++) begin
      tog = ~tog;
      tick(1'b0, {22'd0, 1'b0, tog, 8'($urandom)});
    end
    checks++;
    if (bus.status[5:3] !== 3'd4) begin
      failures++;
      $display("FAIL full_fill count=%0d expected=4", bus.status[5:3]);
    end
    for (int i = 0; i < 60 && m_edge != m_busy_until; i++) begin
      tick(1'b0, {22'd0, 1'b0, tog, 8'h00});
      checks++;
      if (bus.status !== exp_status || bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL full_wait cyc=%0d status=%h/%h tx=%b/%b", i, bus.status, exp_status, bus.tx, exp_tx);
      end
    end
    tog = ~tog;
    tick(1'b0, {22'd0, 1'b0, tog, 8'($urandom)});
    checks++;
    if (bus.status[5:3] !== 3'd4 || bus.status[2] !== 1'b0 || bus.tx !== 1'b0) begin
      failures++;
      $display("FAIL full_simul status=%h tx=%b expected count=4 ovf=0 tx=0", bus.status, bus.tx);
    end
    drain("full");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      tog = ~tog;
      tick(1'b0, {22'd0, 1'b0, tog, 8'($urandom)});
    end
    for (int i = 0; i < 40 && (m_edge - 1 - m_pop_edge) != 17; i++)
      tick(1'b0, {22'd0, 1'b0, tog, 8'h00});
    checks++;
    if (bus.status[5:3] !== 3'd2 || bus.status[1] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_setup status=%h expected count=2 busy=1", bus.status);
    end
    tick(1'b1, {22'd0, 1'b0, tog, 8'h00});
    checks++;
    if (bus.status !== 32'h0 || bus.tx !== 1'b1) begin
      failures++;
      $display("FAIL midrst_edge status=%h tx=%b expected status=0 tx=1", bus.status, bus.tx);
    end
    tog = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 32'h0);
      checks++;
      if (bus.status !== 32'h0 || bus.tx !== 1'b1) begin
        failures++;
        $display("FAIL midrst_quiet cyc=%0d status=%h tx=%b expected status=0 tx=1", i, bus.status, bus.tx);
      end
    end
  endtask

  task automatic test_random();
    logic clr;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) tog = ~tog;
      clr = ($urandom_range(0, 30) == 0);
      tick(1'b0, {$urandom} & 32'hFFFF_FCFF | {22'd0, clr, tog, 8'h00});
      checks++;
      if (bus.status !== exp_status || bus.tx !== exp_tx) begin
        failures++;
        $display("FAIL random cyc=%0d status=%h/%h tx=%b/%b", i, bus.status, exp_status, bus.tx, exp_tx);
      end
    end
    drain("random");
  endtask

  initial begin
    bus.io_out = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped serial output peripheral directly downstream of the CPU's 32-bit io_out port.
- Software writes a byte plus a toggle strobe into io_out. The block queues the byte in a small FIFO and serializes it as 8N1 UART on tx.
- The status word it returns is wired to the CPU's io_in port, so software polls it for handshake acknowledge, busy and overflow.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range >= 2.
- FIFO_DEPTH, 4, byte FIFO entries; legal range 2..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- io_out  input  32  CPU output word. [7:0] data byte; [8] send toggle; [9] overflow clear (level); [31:10] ignored.
- status  output  32  to CPU io_in. [0] ack_toggle; [1] tx_busy; [2] overflow; [5:3] fifo_count; [31:6] zero.
- tx  output  1  UART serial line, idle high, registered.

Behaviour:
- Reset, synchronous while rst=1: tx=1, FIFO empty (count=0), prev_toggle=0, ack_toggle=0, overflow=0, FSM=IDLE. status therefore reads 0.
- Reset mid-frame: the frame is aborted, tx returns to 1 after the edge, and queued bytes are discarded.
- Write detect: at each edge, if io_out[8] != prev_toggle:
  - prev_toggle<=io_out[8].
  - ack_toggle<=io_out[8].
  - If the FIFO is not full, io_out[7:0] is pushed.
  - If the FIFO is full, the byte is dropped and overflow<=1.
- Acknowledge rule: ack_toggle always follows the accepted toggle, so software never deadlocks. Software checks overflow for lost data.
- Overflow clear: io_out[9]=1 clears overflow at the edge. If a set and a clear occur in the same cycle, the set wins.
- FIFO: circular buffer with read/write pointers that wrap at FIFO_DEPTH, plus a count register.
  - Push and pop in the same cycle: count is unchanged. This applies when full; the push is accepted because the pop frees a slot in that cycle.
  - A push into an empty FIFO is not poppable until the following edge; there is no bypass.
- FSM states IDLE, START, DATA, STOP. A bit counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..7.
  - IDLE: tx=1. If count>0: pop into an 8-bit shift register, tx<=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0] and go to DATA with index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7, tx<=1 and go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop, tx<=0, go to START (back-to-back, no idle cycle). Otherwise go to IDLE.
- Latency: from acceptance edge E0, the FSM pops at E1 and tx falls after E1. A full frame is 10*CLKS_PER_BIT cycles of tx low/data/high.
- tx_busy = (FSM != IDLE) or (count != 0).
- status is combinational from registers only; it has no path from io_out.
- io_out is a registered CPU output. A level held constant never re-triggers, because only toggle changes count as writes.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset: hold rst=1 for 3 cycles with io_out=0x1FF -> tx=1, status=0x0. Release with io_out=0 -> status stays 0, tx stays 1.
- Single byte: io_out 0x000 -> 0x155 -> status[0]=1 and count=1 after E0, then count=0 with busy=1. tx low 4 cycles from E1, bits 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles, then status=0x1.
- Back-to-back: toggle in 0xA1 then 0x3C in consecutive toggle writes -> two frames with no idle gap between the stop bit and the second start bit; total tx activity 80 cycles.
- Overflow: issue 6 toggled writes in 6 consecutive cycles while the FIFO drains one byte ->
  - 5 bytes are transmitted: the first is popped at E1 into the shifter, then 4 queued.
  - 1 byte is dropped, status[2]=1, and ack_toggle tracks the last toggle.
  - io_out[9]=1 for one cycle -> status[2]=0.
- Full-FIFO simultaneous push/pop: fill to count=4 with the FSM ending STOP, and push at the same edge as the pop -> count remains 4, overflow remains 0, and byte order is preserved.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> after the edge tx=1 and status=0; no further frames appear after rst is released.
